alu_wb_buffer: RTL
==================

# alu_wb_buffer

Dual-lane writeback buffer that sits directly downstream of the two `ALU_Array` execute lanes of the superscalar core. It accepts up to two ALU results per cycle, each tagged with a destination register. Results are queued in program order and drained to the register file's single write port at one per cycle. It decouples dual-issue execute bandwidth from the single-ported writeback path and applies backpressure to issue when it cannot absorb a full issue pair.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `DW`, 32: result data width.
- `TW`, 5: destination register tag width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; takes effect on the rising edge of `clk` while high.
- `in0_valid` in 1: lane 0 result valid (older instruction of the issue pair).
- `in0_rd` in TW: lane 0 destination register.
- `in0_result` in DW: lane 0 ALU result.
- `in1_valid` in 1: lane 1 result valid (younger instruction).
- `in1_rd` in TW: lane 1 destination register.
- `in1_result` in DW: lane 1 ALU result.
- `in_ready` out 1: buffer can absorb both lanes this cycle.
- `wb_en` out 1: register file write enable.
- `wb_rd` out TW: register file write address.
- `wb_data` out DW: register file write data.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Circular FIFO with `DEPTH` entries of {rd, data}, plus write pointer, read pointer and occupancy count.
- `in_ready = (DEPTH - count) >= 2`. The check is combinational on the registered count only and does not depend on this cycle's pop.
- Accept rule:
  - A lane is enqueued when `in_ready` is high, its valid is high, and its rd ≠ 0.
  - Results targeting x0 are discarded and consume no entry.
- Ordering:
  - If both lanes are enqueued, lane 0 goes to the entry at wptr and lane 1 to wptr+1.
  - If only one lane is enqueued, it goes to wptr.
  - wptr advances by the number of entries enqueued, modulo `DEPTH`.
- Valids presented while `in_ready` is low are ignored, not stored. The upstream issue stage must hold the pair until `in_ready` is high.
- Drain:
  - When `count != 0`: `wb_en = 1`, `wb_rd`/`wb_data` = head entry, and the head is popped at the clock edge. The register file always accepts.
  - When empty: `wb_en = 0`, and `wb_rd` and `wb_data` are forced to 0.
- Occupancy update per cycle: `count_next = count + pushes - pop`, where pushes ∈ {0,1,2} and pop ∈ {0,1}. Push and pop in the same cycle are both honoured.
- Duplicate rd values across lanes or entries are legal. Program order guarantees that the younger write lands last.
- No bypass from input to output: an enqueued result cannot appear on `wb_*` in the same cycle it arrives.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - `count = 0`, wptr = rptr = 0.
  - `in_ready = 1`, `wb_en = 0`, `wb_rd = 0`, `wb_data = 0`.
  - Entry contents are don't-care.
- Reset mid-operation drops all queued entries. Inputs presented in the reset cycle are not enqueued.
- Latency:
  - A result accepted at edge N appears on `wb_*` during cycle N+1 if the buffer was empty.
  - Otherwise it appears after all older entries, at one per cycle.
- Throughput: sustained 1 writeback per cycle. Sustained dual issue therefore fills the buffer, and `in_ready` drops once `count > DEPTH-2`.
- Full boundary:
  - At `count = DEPTH-1` or `count = DEPTH`, `in_ready = 0` even though a pop occurs that cycle.
  - `count` never exceeds `DEPTH`.
- Empty boundary: a pop never occurs at `count = 0`, so `count` never underflows.
- Pointer wrap: each pointer wraps from `DEPTH-1` to 0 with no lost or duplicated entry.

## Test plan
- Reset, then idle → `wb_en = 0`, `wb_rd = 0`, `wb_data = 0`, `count = 0`, `in_ready = 1`.
- Single pair {rd = 3, 0x11111111}, {rd = 4, 0x22222222}, then idle → cycle+1: wb (3, 0x11111111); cycle+2: wb (4, 0x22222222); cycle+3: `wb_en = 0`.
- Lane 0 rd = 0 with lane 1 {rd = 7, 0xDEADBEEF} → only one entry enqueued (`count = 1`), and the single writeback is (7, 0xDEADBEEF).
- Dual pairs every cycle with DEPTH = 4, tags 1..8 → `in_ready` falls after `count` reaches 3; held pairs are accepted later; writeback order is exactly 1, 2, …, 8; `count ≤ 4` throughout.
- 20 single-lane pushes on lane 1 only, one per cycle, data = tag → output matches input one cycle later, covering pointer wrap several times.
- Assert `reset` for one cycle while `count = 3` → next cycle `count = 0` and `wb_en = 0`; the subsequent pair {rd = 9, 0x5} drains correctly.

Source files
------------

// File: rtl/alu_wb_buffer.sv
// Dual-lane ALU writeback buffer: queues up to two tagged results per cycle in program order, drains one per cycle to the register file.
// Latency: a result accepted into an empty buffer is presented on wb_* the following cycle; otherwise it follows all older entries.
// Backpressure: in_ready is low unless two free entries exist (registered count only); valids seen while in_ready is low are dropped.
module alu_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int TW    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in0_valid,
  input  logic [TW-1:0]            in0_rd,
  input  logic [DW-1:0]            in0_result,
  input  logic                     in1_valid,
  input  logic [TW-1:0]            in1_rd,
  input  logic [DW-1:0]            in1_result,
  output logic                     in_ready,
  output logic                     wb_en,
  output logic [TW-1:0]            wb_rd,
  output logic [DW-1:0]            wb_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage; contents are not reset, only the pointers and count are.
  logic [TW-1:0] r_mem_rd   [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_push0;
  logic          w_push1;
  logic          w_pop;
  logic [CW-1:0] w_npush;
  logic [AW-1:0] w_wptr_lane1;

  // Readiness looks only at the registered count so issue never depends on this cycle's drain.
  assign in_ready = (r_count <= CW'(DEPTH - 2));

  // Writes to x0 are architecturally dead, so they never occupy an entry.
  assign w_push0 = in_ready && in0_valid && (in0_rd != '0);
  assign w_push1 = in_ready && in1_valid && (in1_rd != '0);
  assign w_pop   = (r_count != '0);

  assign w_npush = {{(CW-1){1'b0}}, w_push0} + {{(CW-1){1'b0}}, w_push1};

  // Lane 1 lands behind lane 0 only when lane 0 actually took a slot.
  assign w_wptr_lane1 = w_push0 ? r_wptr + AW'(1) : r_wptr;

  assign wb_en   = w_pop;
  assign wb_rd   = w_pop ? r_mem_rd[r_rptr]   : '0;
  assign wb_data = w_pop ? r_mem_data[r_rptr] : '0;
  assign count   = r_count;

  // Entry writes for the accepted lanes, in program order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_push0) begin
        r_mem_rd[r_wptr]   <= in0_rd;
        r_mem_data[r_wptr] <= in0_result;
      end
      if (w_push1) begin
        r_mem_rd[w_wptr_lane1]   <= in1_rd;
        r_mem_data[w_wptr_lane1] <= in1_result;
      end
    end
  end

  // Pointer and occupancy bookkeeping; push and pop in the same cycle both take effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + w_npush[AW-1:0];
      r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_count <= r_count + w_npush - {{(CW-1){1'b0}}, w_pop};
    end
  end

endmodule
